// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational MIPS ALU between two requesters using
//   round-robin arbitration. Each requester has a valid/ready request
//   channel and a one-entry registered response slot. A request accepted
//   in cycle N produces its response in cycle N+1.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   rN_valid/rN_ready        request handshake for requester N (0 or 1)
//   rN_a/b/oper/sign/tag     request fields; tag is returned with the result
//   rN_rsp_valid/rsp_ready   response handshake for requester N
//   rN_rsp_result/rsp_tag    registered ALU result and its tag
//   alu_a/b/oper/sign        operands to the shared ALU (zero when idle)
//   alu_result               combinational result from the shared ALU
//
// Handshake semantics: a transfer happens on a rising edge where both
// valid and ready are high. A requester holds valid and all fields stable
// until ready is seen. ready is combinational and may depend on valid. A
// response is consumed on an edge where rsp_valid and rsp_ready are both
// high; the slot may refill on that same edge.
module alu_share_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [31:0]      r0_a,
  input  logic [31:0]      r0_b,
  input  logic [3:0]       r0_oper,
  input  logic             r0_sign,
  input  logic [TAG_W-1:0] r0_tag,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic [31:0]      r0_rsp_result,
  output logic [TAG_W-1:0] r0_rsp_tag,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [31:0]      r1_a,
  input  logic [31:0]      r1_b,
  input  logic [3:0]       r1_oper,
  input  logic             r1_sign,
  input  logic [TAG_W-1:0] r1_tag,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [31:0]      r1_rsp_result,
  output logic [TAG_W-1:0] r1_rsp_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_oper,
  output logic             alu_sign,
  input  logic [31:0]      alu_result
);

  // last_gnt = 1 means requester 1 was granted most recently, so
  // requester 0 wins the next tie (this is the reset value).
  logic last_gnt;
  logic slot_free0, slot_free1;
  logic elig0, elig1;
  logic gnt0, gnt1;

  // A slot being drained this cycle can accept a new result on the same edge.
  assign slot_free0 = ~r0_rsp_valid | r0_rsp_ready;
  assign slot_free1 = ~r1_rsp_valid | r1_rsp_ready;

  assign elig0 = r0_valid & slot_free0 & ~rst;
  assign elig1 = r1_valid & slot_free1 & ~rst;

  assign gnt0 = elig0 & (~elig1 | last_gnt);
  assign gnt1 = elig1 & (~elig0 | ~last_gnt);

  assign r0_ready = gnt0;
  assign r1_ready = gnt1;

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_oper = '0;
    alu_sign = 1'b0;
    if (gnt0) begin
      alu_a    = r0_a;
      alu_b    = r0_b;
      alu_oper = r0_oper;
      alu_sign = r0_sign;
    end else if (gnt1) begin
      alu_a    = r1_a;
      alu_b    = r1_b;
      alu_oper = r1_oper;
      alu_sign = r1_sign;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (gnt0) begin
      last_gnt <= 1'b0;
    end else if (gnt1) begin
      last_gnt <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r0_rsp_valid  <= 1'b0;
      r0_rsp_result <= '0;
      r0_rsp_tag    <= '0;
    end else if (gnt0) begin
      r0_rsp_valid  <= 1'b1;
      r0_rsp_result <= alu_result;
      r0_rsp_tag    <= r0_tag;
    end else if (r0_rsp_ready) begin
      r0_rsp_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_rsp_valid  <= 1'b0;
      r1_rsp_result <= '0;
      r1_rsp_tag    <= '0;
    end else if (gnt1) begin
      r1_rsp_valid  <= 1'b1;
      r1_rsp_result <= alu_result;
      r1_rsp_tag    <= r1_tag;
    end else if (r1_rsp_ready) begin
      r1_rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
  localparam int TAG_W = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SLT = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SL  = 4'd6;
  localparam logic [3:0] OP_SR  = 4'd7;
  localparam logic [3:0] OP_LUI = 4'd8;

  logic             clk = 1'b0;
  logic             rst;
  logic             r0_valid, r0_ready, r0_sign, r0_rsp_valid, r0_rsp_ready;
  logic [31:0]      r0_a, r0_b, r0_rsp_result;
  logic [3:0]       r0_oper;
  logic [TAG_W-1:0] r0_tag, r0_rsp_tag;
  logic             r1_valid, r1_ready, r1_sign, r1_rsp_valid, r1_rsp_ready;
  logic [31:0]      r1_a, r1_b, r1_rsp_result;
  logic [3:0]       r1_oper;
  logic [TAG_W-1:0] r1_tag, r1_rsp_tag;
  logic [31:0]      alu_a, alu_b, alu_result;
  logic [3:0]       alu_oper;
  logic             alu_sign;

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  alu_share_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_oper(r0_oper), .r0_sign(r0_sign), .r0_tag(r0_tag),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r0_rsp_result(r0_rsp_result), .r0_rsp_tag(r0_rsp_tag),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_oper(r1_oper), .r1_sign(r1_sign), .r1_tag(r1_tag),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .r1_rsp_result(r1_rsp_result), .r1_rsp_tag(r1_rsp_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper), .alu_sign(alu_sign),
    .alu_result(alu_result)
  );

  // Stand-in for the shared MIPS ALU (shift amount in a, shifted value in b).
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op, input logic s);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return s ? {31'd0, $signed(a) < $signed(b)} : {31'd0, a < b};
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SL:   return b << a[4:0];
      OP_SR:   return s ? 32'($signed(b) >>> a[4:0]) : (b >> a[4:0]);
      OP_LUI:  return {b[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_result = alu_ref(alu_a, alu_b, alu_oper, alu_sign);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- scoreboard / reference model ----------------
  // Each port's response slot is a queue holding at most one {tag,result}.
  // hold_* keeps the last value written so the held outputs can be checked.
  logic [TAG_W+31:0] exp_q0[$];
  logic [TAG_W+31:0] exp_q1[$];
  logic [TAG_W+31:0] hold0 = '0;
  logic [TAG_W+31:0] hold1 = '0;
  int prefer = 0; // requester that wins the next tie

  always @(negedge clk) begin
    logic [1:0] want, exp_g;
    logic [31:0] ea, eb;
    logic [3:0] eo;
    logic es;
    chk("r0_rsp_valid", {31'd0, r0_rsp_valid}, {31'd0, exp_q0.size() != 0});
    chk("r1_rsp_valid", {31'd0, r1_rsp_valid}, {31'd0, exp_q1.size() != 0});
    chk("r0_rsp_result", r0_rsp_result, hold0[31:0]);
    chk("r1_rsp_result", r1_rsp_result, hold1[31:0]);
    chk("r0_rsp_tag", {28'd0, r0_rsp_tag}, {28'd0, hold0[TAG_W+31:32]});
    chk("r1_rsp_tag", {28'd0, r1_rsp_tag}, {28'd0, hold1[TAG_W+31:32]});
    want[0] = !rst && r0_valid && (exp_q0.size() == 0 || r0_rsp_ready);
    want[1] = !rst && r1_valid && (exp_q1.size() == 0 || r1_rsp_ready);
    if (want == 2'b11) exp_g = (prefer == 0) ? 2'b01 : 2'b10;
    else exp_g = want;
    chk("r0_ready", {31'd0, r0_ready}, {31'd0, exp_g[0]});
    chk("r1_ready", {31'd0, r1_ready}, {31'd0, exp_g[1]});
    ea = 0; eb = 0; eo = 0; es = 0;
    if (exp_g[0]) begin ea = r0_a; eb = r0_b; eo = r0_oper; es = r0_sign; end
    if (exp_g[1]) begin ea = r1_a; eb = r1_b; eo = r1_oper; es = r1_sign; end
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    chk("alu_oper", {28'd0, alu_oper}, {28'd0, eo});
    chk("alu_sign", {31'd0, alu_sign}, {31'd0, es});
    // state for the next cycle
    if (rst) begin
      exp_q0.delete(); exp_q1.delete();
      hold0 = '0; hold1 = '0; prefer = 0;
    end else begin
      if (r0_rsp_ready && exp_q0.size() != 0) void'(exp_q0.pop_front());
      if (r1_rsp_ready && exp_q1.size() != 0) void'(exp_q1.pop_front());
      if (exp_g[0]) begin
        hold0 = {r0_tag, alu_ref(r0_a, r0_b, r0_oper, r0_sign)};
        exp_q0.push_back(hold0);
        prefer = 1;
      end
      if (exp_g[1]) begin
        hold1 = {r1_tag, alu_ref(r1_a, r1_b, r1_oper, r1_sign)};
        exp_q1.push_back(hold1);
        prefer = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic s, input logic [TAG_W-1:0] t);
    r0_valid = v; r0_a = a; r0_b = b; r0_oper = op; r0_sign = s; r0_tag = t;
  endtask

  task automatic req1(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic s, input logic [TAG_W-1:0] t);
    r1_valid = v; r1_a = a; r1_b = b; r1_oper = op; r1_sign = s; r1_tag = t;
  endtask

  task automatic do_reset();
    rst = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic rand_req0();
    req0($urandom_range(0, 2) != 0, $urandom, $urandom, 4'($urandom_range(0, 9)),
         1'($urandom_range(0, 1)), TAG_W'($urandom));
  endtask

  task automatic rand_req1();
    req1($urandom_range(0, 2) != 0, $urandom, $urandom, 4'($urandom_range(0, 9)),
         1'($urandom_range(0, 1)), TAG_W'($urandom));
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] sg_a[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4, 32'd4, 32'd0};
  logic [31:0] sg_b[5]  = '{32'd1, 32'd1, 32'h8000_0000, 32'h8000_0000, 32'h0000_1234};
  logic [3:0]  sg_o[5]  = '{OP_SLT, OP_SLT, OP_SR, OP_SR, OP_LUI};
  logic        sg_s[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] sg_r[5]  = '{32'd1, 32'd0, 32'hF800_0000, 32'h0800_0000, 32'h1234_0000};

  initial begin
    logic acc0, acc1;
    rst = 1'b1;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    req0(1'b1, 32'd1, 32'd2, OP_ADD, 1'b0, 4'd1);
    req1(1'b1, 32'd3, 32'd4, OP_ADD, 1'b0, 4'd2);

    // reset held two cycles with both requests valid
    for (int k = 0; k < 2; k++) begin
      tick(); #1;
      chk("rst_r0_ready", {31'd0, r0_ready}, 32'd0);
      chk("rst_r1_ready", {31'd0, r1_ready}, 32'd0);
      chk("rst_r0_rsp_valid", {31'd0, r0_rsp_valid}, 32'd0);
      chk("rst_r1_rsp_valid", {31'd0, r1_rsp_valid}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_oper", {28'd0, alu_oper}, 32'd0);
    end
    tick();
    rst = 1'b0;

    // contention: strict alternation starting with r0
    req0(1'b1, 32'd1, 32'd1, OP_ADD, 1'b0, 4'd5);
    req1(1'b1, 32'd10, 32'd3, OP_SUB, 1'b0, 4'd9);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("cont_r0_ready", {31'd0, r0_ready}, {31'd0, (k % 2) == 0});
      chk("cont_r1_ready", {31'd0, r1_ready}, {31'd0, (k % 2) == 1});
      if (k % 2 == 1) chk("cont_r0_result", r0_rsp_result, 32'd2);
      if (k > 0 && k % 2 == 0) chk("cont_r1_result", r1_rsp_result, 32'd7);
      tick();
    end

    // single port
    do_reset();
    req0(1'b1, 32'd5, 32'd7, OP_ADD, 1'b0, 4'd3);
    #1;
    chk("single_r0_ready", {31'd0, r0_ready}, 32'd1);
    chk("single_r1_ready", {31'd0, r1_ready}, 32'd0);
    tick();
    r0_valid = 1'b0;
    #1;
    chk("single_rsp_valid", {31'd0, r0_rsp_valid}, 32'd1);
    chk("single_rsp_result", r0_rsp_result, 32'd12);
    chk("single_rsp_tag", {28'd0, r0_rsp_tag}, 32'd3);
    chk("single_r1_rsp_valid", {31'd0, r1_rsp_valid}, 32'd0);
    tick();

    // back-pressure on r0 while r1 streams
    r0_rsp_ready = 1'b0;
    req0(1'b1, 32'd5, 32'd7, OP_ADD, 1'b0, 4'd1);
    tick();
    req0(1'b1, 32'd2, 32'd2, OP_ADD, 1'b0, 4'd2);
    req1(1'b1, 32'd10, 32'd3, OP_SUB, 1'b0, 4'd4);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_r0_ready", {31'd0, r0_ready}, 32'd0);
      chk("bp_r1_ready", {31'd0, r1_ready}, 32'd1);
      chk("bp_r0_result", r0_rsp_result, 32'd12);
      tick();
    end
    r0_rsp_ready = 1'b1;
    #1;
    chk("bp_release_r0_ready", {31'd0, r0_ready}, 32'd1);
    chk("bp_release_r1_ready", {31'd0, r1_ready}, 32'd0);
    tick();
    r0_valid = 1'b0; r1_valid = 1'b0;
    #1;
    chk("bp_next_result", r0_rsp_result, 32'd4);
    chk("bp_next_tag", {28'd0, r0_rsp_tag}, 32'd2);
    tick();

    // signedness / ALU pass-through
    for (int k = 0; k < 5; k++) begin
      req0(1'b1, sg_a[k], sg_b[k], sg_o[k], sg_s[k], TAG_W'(k));
      tick();
      r0_valid = 1'b0;
      #1;
      chk("pass_result", r0_rsp_result, sg_r[k]);
    end
    tick();

    // reset mid-flight: r0 response pending, r1 won last
    r0_rsp_ready = 1'b0;
    req0(1'b1, 32'd1, 32'd2, OP_ADD, 1'b0, 4'd7);
    tick();
    r0_valid = 1'b0;
    req1(1'b1, 32'd3, 32'd4, OP_ADD, 1'b0, 4'd8);
    tick();
    rst = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    chk("mid_rst_r0_ready", {31'd0, r0_ready}, 32'd0);
    chk("mid_rst_r1_ready", {31'd0, r1_ready}, 32'd0);
    chk("mid_pending", {31'd0, r0_rsp_valid}, 32'd1);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_after_r0_rsp_valid", {31'd0, r0_rsp_valid}, 32'd0);
    chk("mid_after_r1_rsp_valid", {31'd0, r1_rsp_valid}, 32'd0);
    chk("mid_tie_r0", {31'd0, r0_ready}, 32'd1);
    tick();
    // r0 won last; a reset must still hand the next tie to r0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_tie_r0", {31'd0, r0_ready}, 32'd1);
    chk("rst_tie_r1", {31'd0, r1_ready}, 32'd0);
    tick();

    // randomized traffic; a pending request is held until accepted
    acc0 = 1'b0; acc1 = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!r0_valid || acc0) rand_req0();
      if (!r1_valid || acc1) rand_req1();
      r0_rsp_ready = ($urandom_range(0, 3) != 0);
      r1_rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      #2;
      acc0 = r0_ready; acc1 = r1_ready;
      tick();
    end
    rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
